// File: rtl/calculator_input.sv
// calculator_input: synchronizes and debounces five pushbuttons and sixteen switches into
// single-pulse start/buttons/switch commands. Define CALC_DEBOUNCE_EN to include the debounce counters.
module calculator_input #(
    parameter int DB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         buttons_raw,
    input  logic [15:0]        switch_raw,
    output logic               start,
    output logic [4:0]         buttons,
    output logic signed [15:0] switch,
    output logic               busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    if (DB_CYCLES < 1) begin : g_db_cycles_illegal
        $error("calculator_input: DB_CYCLES must be at least 1");
    end

    function automatic logic [4:0] lowest_set(input logic [4:0] v);
        lowest_set = v & (~v + 5'd1);
    endfunction

    logic [4:0]  bmeta_q, bmeta_d;
    logic [4:0]  bs_q, bs_d;
    logic [15:0] smeta_q, smeta_d;
    logic [15:0] ss_q, ss_d;
    logic [4:0]  db_s;
    logic [4:0]  db_prev_q, db_prev_d;
    logic [4:0]  rise_s;
    logic [0:0]  state_q, state_d;
    logic        start_q, start_d;
    logic [4:0]  buttons_q, buttons_d;
    logic [15:0] switch_q, switch_d;
    logic        busy_q, busy_d;

    // Two-stage synchronizers and the one-cycle delayed debounced value
    always_comb begin
        bmeta_d   = buttons_raw;
        bs_d      = bmeta_q;
        smeta_d   = switch_raw;
        ss_d      = smeta_q;
        db_prev_d = db_s;
    end

    // Synchronizer and delay registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bmeta_q   <= 5'd0;
            bs_q      <= 5'd0;
            smeta_q   <= 16'd0;
            ss_q      <= 16'd0;
            db_prev_q <= 5'd0;
        end else begin
            bmeta_q   <= bmeta_d;
            bs_q      <= bs_d;
            smeta_q   <= smeta_d;
            ss_q      <= ss_d;
            db_prev_q <= db_prev_d;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int              CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(1'b0);

    logic [4:0][CW-1:0] cnt_q, cnt_d;
    logic [4:0]         db_q, db_d;

    // Per-button run-length counter: db flips only after DB_CYCLES disagreeing samples in a row
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < 5; i++) begin
            if (bs_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = bs_q[i];
                cnt_d[i] = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {5{CNT_ZERO}};
            db_q  <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_s = db_q;
`else
    assign db_s = bs_q;
`endif

    assign rise_s = db_s & ~db_prev_q;

    // Command FSM: one event per press, then wait for every button to be released
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        buttons_d = buttons_q;
        switch_d  = switch_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s != 5'd0) begin
                    start_d   = 1'b1;
                    buttons_d = lowest_set(rise_s);
                    switch_d  = ss_q;
                    state_d   = ST_HELD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (db_s == 5'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_HELD);
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            buttons_q <= 5'd0;
            switch_q  <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            buttons_q <= buttons_d;
            switch_q  <= switch_d;
            busy_q    <= busy_d;
        end
    end

    assign start   = start_q;
    assign buttons = buttons_q;
    assign switch  = switch_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_calculator_input.sv
// Self-checking bench for calculator_input: vector table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a window-based reference model.
module tb_calculator_input;

    localparam int DB = 4;
`ifdef CALC_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [4:0]         buttons_raw;
    logic [15:0]        switch_raw;
    logic               start;
    logic [4:0]         buttons;
    logic signed [15:0] switch;
    logic               busy;

    int checks = 0;
    int errors = 0;

    calculator_input #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .reset(reset),
        .buttons_raw(buttons_raw),
        .switch_raw(switch_raw),
        .start(start),
        .buttons(buttons),
        .switch(switch),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: rb[i] / rs[i] hold the raw inputs sampled i+1 edges ago
    logic [4:0]  rb [0:DB];
    logic [15:0] rs [0:1];
    logic [4:0]  m_db, m_db_prev, m_buttons;
    logic [15:0] m_switch;
    logic        m_held, m_start;

    function automatic logic [4:0] pick_lowest(input logic [4:0] v);
        logic [4:0] r = 5'd0;
        for (int i = 4; i >= 0; i--) if (v[i]) r = 5'd1 << i;
        return r;
    endfunction

    // A button's debounced level follows its synchronized level once that level was steady for DB samples
    function automatic logic [4:0] next_db(input logic [4:0] cur);
        logic [4:0] r = cur;
`ifdef CALC_DEBOUNCE_EN
        for (int b = 0; b < 5; b++) begin
            logic steady = 1'b1;
            for (int i = 2; i <= DB; i++) if (rb[i][b] != rb[1][b]) steady = 1'b0;
            if (steady) r[b] = rb[1][b];
        end
`else
        r = rb[0];
`endif
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DB; i++) rb[i] <= 5'd0;
            rs[0] <= 16'd0; rs[1] <= 16'd0;
            m_db <= 5'd0; m_db_prev <= 5'd0; m_held <= 1'b0;
            m_start <= 1'b0; m_buttons <= 5'd0; m_switch <= 16'd0;
        end else begin
            for (int i = 1; i <= DB; i++) rb[i] <= rb[i-1];
            rb[0] <= buttons_raw;
            rs[1] <= rs[0];
            rs[0] <= switch_raw;
            if (!m_held) begin
                if ((m_db & ~m_db_prev) != 5'd0) begin
                    m_start   <= 1'b1;
                    m_buttons <= pick_lowest(m_db & ~m_db_prev);
                    m_switch  <= rs[1];
                    m_held    <= 1'b1;
                end else begin
                    m_start <= 1'b0;
                end
            end else begin
                m_start <= 1'b0;
                if (m_db == 5'd0) m_held <= 1'b0;
            end
            m_db_prev <= m_db;
            m_db      <= next_db(m_db);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 25) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model", {9'd0, start, busy, buttons, switch}, {9'd0, m_start, m_held, m_buttons, m_switch});
    endtask

    task automatic wait_start(output int j);
        j = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (start) begin j = k; break; end
        end
    endtask

    task automatic wait_idle(output int j);
        j = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (!busy) begin j = k; break; end
        end
    endtask

    typedef struct {
        logic [4:0]  btn;
        logic [15:0] sw;
        logic [4:0]  exp_btn;
        logic [15:0] exp_sw;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int j;
        switch_raw  = v.sw;
        buttons_raw = v.btn;
        wait_start(j);
        chk("press_latency", j, LAT + 1);
        chk("op_code", {27'd0, buttons}, {27'd0, v.exp_btn});
        chk("operand", {16'd0, switch}, {16'd0, v.exp_sw});
        chk("busy_on", {31'd0, busy}, 32'd1);
        tick();
        chk("start_width", {31'd0, start}, 32'd0);
        repeat (20) tick();
        buttons_raw = 5'd0;
        switch_raw  = ~v.sw;
        wait_idle(j);
        chk("release_latency", j, LAT + 1);
        chk("op_held", {27'd0, buttons}, {27'd0, v.exp_btn});
        chk("operand_held", {16'd0, switch}, {16'd0, v.exp_sw});
        repeat (3) tick();
    endtask

    vec_t vecs [6];

    initial begin
        int j;
        logic seen;

        vecs[0] = '{5'b00001, 16'h0007, 5'b00001, 16'h0007};
        vecs[1] = '{5'b01010, 16'h1234, 5'b00010, 16'h1234};
        vecs[2] = '{5'b10000, 16'hFFFE, 5'b10000, 16'hFFFE};
        vecs[3] = '{5'b11000, 16'h8000, 5'b01000, 16'h8000};
        vecs[4] = '{5'b00100, 16'h7FFF, 5'b00100, 16'h7FFF};
        vecs[5] = '{5'b11111, 16'hA5A5, 5'b00001, 16'hA5A5};

        reset = 1'b1; buttons_raw = 5'd0; switch_raw = 16'h5555;
        repeat (3) @(negedge clk);
        chk("reset_start", {31'd0, start}, 32'd0);
        chk("reset_buttons", {27'd0, buttons}, 32'd0);
        chk("reset_switch", {16'd0, switch}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        #1 reset = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef CALC_DEBOUNCE_EN
        // Bounce on LEFT: a 3-cycle pulse must be swallowed
        seen = 1'b0;
        buttons_raw = 5'b00100;
        repeat (3) begin tick(); seen |= start; end
        buttons_raw = 5'b00000;
        tick(); seen |= start;
        chk("glitch_no_start", {31'd0, seen}, 32'd0);
        buttons_raw = 5'b00100;
        wait_start(j);
        chk("bounce_latency", j, LAT + 1);
        chk("bounce_op", {27'd0, buttons}, 32'd4);
`else
        // Without debounce a single-cycle pulse is a legal press
        buttons_raw = 5'b00001;
        tick();
        buttons_raw = 5'b00000;
        wait_start(j);
        chk("glitch_start_latency", j, LAT);
`endif
        buttons_raw = 5'd0;
        wait_idle(j);
        repeat (3) tick();

        // Overlap: CENTER pressed while DOWN held generates nothing
        switch_raw  = 16'h0003;
        buttons_raw = 5'b00010;
        wait_start(j);
        chk("overlap_first", {27'd0, buttons}, 32'd2);
        buttons_raw = 5'b10010;
        seen = 1'b0;
        repeat (20) begin tick(); seen |= start; end
        buttons_raw = 5'b10000;
        repeat (20) begin tick(); seen |= start; end
        chk("overlap_no_start", {31'd0, seen}, 32'd0);
        chk("overlap_busy", {31'd0, busy}, 32'd1);
        buttons_raw = 5'd0;
        wait_idle(j);
        chk("overlap_release", j, LAT + 1);
        repeat (2) tick();
        buttons_raw = 5'b10000;
        wait_start(j);
        chk("center_after_release", {27'd0, buttons}, 32'h10);
        buttons_raw = 5'd0;
        wait_idle(j);
        repeat (3) tick();

        // Operand capture: switch change one edge before start must not leak in
        switch_raw  = 16'hFFFE;
        buttons_raw = 5'b00100;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k == LAT - 1) switch_raw = 16'h0005;
        end
        chk("capture_start", {31'd0, start}, 32'd1);
        chk("capture_operand", {16'd0, switch}, 32'h0000FFFE);
        chk("calc_left", 32'(10 + int'(switch)), 32'd8);
        repeat (5) tick();
        chk("capture_hold", {16'd0, switch}, 32'h0000FFFE);
        buttons_raw = 5'd0;
        wait_idle(j);
        repeat (3) tick();

        // Async reset mid-count, then mid-HELD, with UP held through both
        switch_raw  = 16'h00A5;
        buttons_raw = 5'b00001;
        repeat (2) tick();
        #2 reset = 1'b1;
        #1 chk("rst_count_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        #1 reset = 1'b0;
        wait_start(j);
        chk("rst_count_relaunch", j, LAT + 1);
        chk("rst_count_op", {27'd0, buttons}, 32'd1);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1 chk("rst_held_out", {10'd0, start, busy, buttons, switch}, 32'd0);
        repeat (2) tick();
        #1 reset = 1'b0;
        wait_start(j);
        chk("rst_held_relaunch", j, LAT + 1);
        chk("rst_held_operand", {16'd0, switch}, 32'h00A5);
        buttons_raw = 5'd0;
        wait_idle(j);
        repeat (3) tick();

        // Randomized presses, chords and glitches, checked cycle by cycle against the model
        for (int it = 0; it < 200; it++) begin
            buttons_raw = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            repeat ($urandom_range(1, 12)) begin
                switch_raw = 16'($urandom);
                tick();
            end
        end
        buttons_raw = 5'd0;
        repeat (LAT + 4) tick();
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
